// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: load-type codes, datapath defaults and the zero register.
// Imported by every MEM/WB block.
package cpu_defs_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 32;

    localparam logic [2:0] LDTYPE_LB  = 3'd0;
    localparam logic [2:0] LDTYPE_LBU = 3'd1;
    localparam logic [2:0] LDTYPE_LH  = 3'd2;
    localparam logic [2:0] LDTYPE_LHU = 3'd3;
    localparam logic [2:0] LDTYPE_LW  = 3'd4;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bundle plus the register-file write port driven by the WB register.
// master = MEM side / environment, slave = the mem_wb_stage itself.
interface mem_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              stall_i;
    logic              flush_i;
    logic              mem_valid_i;
    logic              mem_wreg_i;
    logic [ADDR_W-1:0] mem_waddr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_load_i;
    logic [2:0]        mem_ldtype_i;
    logic [1:0]        mem_byteoff_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_waddr_o;
    logic [DATA_W-1:0] wb_wdata_o;
    logic              wb_valid_o;
    logic              wb_alignerr_o;
    logic [CNT_W-1:0]  retire_cnt_o;

    modport master (
        output stall_i, flush_i, mem_valid_i, mem_wreg_i,
        output mem_waddr_i, mem_wdata_i, mem_load_i,
        output mem_ldtype_i, mem_byteoff_i, mem_rdata_i,
        input  wb_we_o, wb_waddr_o, wb_wdata_o,
        input  wb_valid_o, wb_alignerr_o, retire_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, mem_valid_i, mem_wreg_i,
        input  mem_waddr_i, mem_wdata_i, mem_load_i,
        input  mem_ldtype_i, mem_byteoff_i, mem_rdata_i,
        output wb_we_o, wb_waddr_o, wb_wdata_o,
        output wb_valid_o, wb_alignerr_o, retire_cnt_o
    );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load-data formatter: picks the addressed byte/half of a little-endian word,
// extends it, and flags halfword/word accesses that are not naturally aligned.
module load_align
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        ldtype,
    input  logic [1:0]        byteoff,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select: byte by full offset, half by offset bit 1.
    always_comb begin
        byte_sel = 8'h00;
        unique case (byteoff)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
        endcase
        half_sel = byteoff[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension and alignment check; unknown codes behave as a word load.
    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (ldtype)
            LDTYPE_LB: begin
                data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            end
            LDTYPE_LBU: begin
                data = {{(DATA_W-8){1'b0}}, byte_sel};
            end
            LDTYPE_LH: begin
                data       = {{(DATA_W-16){half_sel[15]}}, half_sel};
                misaligned = byteoff[0];
            end
            LDTYPE_LHU: begin
                data       = {{(DATA_W-16){1'b0}}, half_sel};
                misaligned = byteoff[0];
            end
            default: begin
                data       = rdata;
                misaligned = (byteoff != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, suppresses misaligned or $0
// writes, drives the register-file write port and counts retirements.
module mem_wb_stage
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic clk,
    input logic rst,
    mem_wb_if.slave bus
);

    logic [DATA_W-1:0] ld_data;
    logic              ld_mis;

    logic              mis;
    logic [DATA_W-1:0] new_data;
    logic              new_we;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              valid_q;
    logic              alignerr_q;
    logic [CNT_W-1:0]  cnt_q;

    load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .rdata      (bus.mem_rdata_i),
        .ldtype     (bus.mem_ldtype_i),
        .byteoff    (bus.mem_byteoff_i),
        .data       (ld_data),
        .misaligned (ld_mis)
    );

    // Next-slot contents: loads take formatted data, others pass ALU result.
    always_comb begin
        mis      = bus.mem_load_i & ld_mis;
        new_data = bus.mem_load_i ? ld_data : bus.mem_wdata_i;
        new_we   = bus.mem_wreg_i & ~mis
                 & (bus.mem_waddr_i != ADDR_W'(ZERO_REG));
    end

    // WB register: reset > flush > stall > load-new.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            valid_q    <= 1'b0;
            alignerr_q <= 1'b0;
        end else if (bus.flush_i) begin
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            valid_q    <= 1'b0;
            alignerr_q <= 1'b0;
        end else if (bus.stall_i) begin
            alignerr_q <= 1'b0;
        end else if (!bus.mem_valid_i) begin
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            valid_q    <= 1'b0;
            alignerr_q <= 1'b0;
        end else begin
            we_q       <= new_we;
            waddr_q    <= bus.mem_waddr_i;
            wdata_q    <= new_data;
            valid_q    <= 1'b1;
            alignerr_q <= mis;
        end
    end

    // Retire counter: one per real instruction accepted into WB.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!bus.flush_i && !bus.stall_i && bus.mem_valid_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.wb_we_o       = we_q;
    assign bus.wb_waddr_o    = waddr_q;
    assign bus.wb_wdata_o    = wdata_q;
    assign bus.wb_valid_o    = valid_q;
    assign bus.wb_alignerr_o = alignerr_q;
    assign bus.retire_cnt_o  = cnt_q;

endmodule
